// File: rtl/bitlet_buffer_loader.sv
// Write-side sequencer for the Bitlet operand buffer array: streams N words into slots 0..N-1,
// then presents the frame until the PE acknowledges. Optional frame counter: BITLET_LOADER_FRAME_CNT_EN.
//
// state | meaning
// FILL  | accepting words, writing slot idx on the cycle after each accept
// DRAIN | last slot write is on the array port; one cycle only
// FULL  | array holds the whole frame, frame_valid=1 until PE handshake or flush
module bitlet_buffer_loader #(
    parameter  int N  = 4,
    parameter  int W  = 16,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          buf_enw,
    output logic [SW-1:0] buf_sel,
    output logic [W-1:0]  buf_di,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [SW:0]   fill_level,
    output logic [15:0]   frame_cnt
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic [SW-1:0] IDX_ONE  = SW'(1);
    localparam logic [SW:0]   LVL_ONE  = (SW + 1)'(1);

    logic [1:0]    state;
    logic [SW-1:0] idx;
    logic          accept;
    logic          handshake;

    assign in_ready  = (state == S_FILL);
    assign accept    = in_valid && in_ready && !flush;
    // A flush in FULL abandons the frame, so it must not count as a handshake.
    assign handshake = frame_valid && frame_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            idx         <= '0;
            fill_level  <= '0;
            buf_enw     <= 1'b0;
            buf_sel     <= '0;
            buf_di      <= '0;
            frame_valid <= 1'b0;
        end else begin
            buf_enw <= accept;
            if (accept) begin
                buf_sel <= idx;
                buf_di  <= in_data;
            end
            case (state)
                S_FILL: begin
                    if (flush) begin
                        idx        <= '0;
                        fill_level <= '0;
                    end else if (accept) begin
                        fill_level <= fill_level + LVL_ONE;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        state      <= S_FILL;
                        idx        <= '0;
                        fill_level <= '0;
                    end else begin
                        state       <= S_FULL;
                        frame_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (flush || handshake) begin
                        state       <= S_FILL;
                        idx         <= '0;
                        fill_level  <= '0;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_FILL;
                    idx         <= '0;
                    fill_level  <= '0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BITLET_LOADER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (handshake) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_bitlet_buffer_loader.sv
// Self-checking bench: an N=4 and an N=3 loader driven by directed and random steps,
// compared every cycle against a queue-style frame model.
module tb_bitlet_buffer_loader;

`ifdef BITLET_LOADER_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, valid_a, flush_a, fready_a;
    logic [15:0] data_a;
    logic        ready_a, enw_a, fv_a;
    logic [1:0]  sel_a;
    logic [15:0] di_a, cnt_a;
    logic [2:0]  fill_a;

    logic        rst_b, valid_b, flush_b, fready_b;
    logic [15:0] data_b;
    logic        ready_b, enw_b, fv_b;
    logic [1:0]  sel_b;
    logic [15:0] di_b, cnt_b;
    logic [2:0]  fill_b;

    bitlet_buffer_loader #(.N(4), .W(16)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
        .flush(flush_a), .buf_enw(enw_a), .buf_sel(sel_a), .buf_di(di_a),
        .frame_valid(fv_a), .frame_ready(fready_a), .fill_level(fill_a), .frame_cnt(cnt_a)
    );

    bitlet_buffer_loader #(.N(3), .W(16)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
        .flush(flush_b), .buf_enw(enw_b), .buf_sel(sel_b), .buf_di(di_b),
        .frame_valid(fv_b), .frame_ready(fready_b), .fill_level(fill_b), .frame_cnt(cnt_b)
    );

    // Buffer arrays written by the loaders' write ports
    logic [15:0] arr_a [4];
    logic [15:0] arr_b [4];
    always @(posedge clk) begin
        if (enw_a) arr_a[sel_a] <= di_a;
        if (enw_b) arr_b[sel_b] <= di_b;
    end

    int checks = 0;
    int errors = 0;

    // Frame model: words accepted so far in the frame, and whether the frame is presented
    logic [15:0] m_words [2][4];
    int          m_cnt [2];
    bit          m_present [2];
    logic        m_enw [2];
    logic [1:0]  m_sel [2];
    logic [15:0] m_di [2];
    logic [15:0] m_frames [2];
    int          frames_done [2];

    function automatic int nslots(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s_%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_edge(int d, logic r, logic v, logic [15:0] data, logic fl, logic fr);
        bit complete, acc;
        if (r) begin
            m_cnt[d] = 0; m_present[d] = 0; m_enw[d] = 0;
            m_sel[d] = '0; m_di[d] = '0; m_frames[d] = '0; frames_done[d] = 0;
        end else begin
            complete = (m_cnt[d] == nslots(d));
            acc = v && !complete && !fl;
            m_enw[d] = acc;
            if (acc) begin
                m_sel[d] = 2'(m_cnt[d]);
                m_di[d] = data;
                m_words[d][m_cnt[d]] = data;
                m_cnt[d]++;
            end
            if (fl) begin
                m_cnt[d] = 0; m_present[d] = 0;
            end else if (m_present[d] && fr) begin
                m_cnt[d] = 0; m_present[d] = 0; frames_done[d]++;
                if (CNT_EN) m_frames[d] = m_frames[d] + 16'd1;
            end else if (complete && !m_present[d]) begin
                m_present[d] = 1;
            end
        end
    endtask

    task automatic check_all(int d);
        logic        rdy, fv, enw;
        logic [1:0]  sel;
        logic [15:0] di, cnt;
        logic [2:0]  fill;
        logic [15:0] arr [4];
        if (d == 0) begin
            rdy = ready_a; fv = fv_a; enw = enw_a; sel = sel_a; di = di_a; cnt = cnt_a; fill = fill_a; arr = arr_a;
        end else begin
            rdy = ready_b; fv = fv_b; enw = enw_b; sel = sel_b; di = di_b; cnt = cnt_b; fill = fill_b; arr = arr_b;
        end
        chk("in_ready", d, 32'(rdy), 32'(m_cnt[d] < nslots(d)));
        chk("frame_valid", d, 32'(fv), 32'(m_present[d]));
        chk("fill_level", d, 32'(fill), 32'(m_cnt[d]));
        chk("buf_enw", d, 32'(enw), 32'(m_enw[d]));
        chk("buf_sel", d, 32'(sel), 32'(m_sel[d]));
        chk("buf_di", d, 32'(di), 32'(m_di[d]));
        chk("frame_cnt", d, 32'(cnt), 32'(m_frames[d]));
        chk("sel_range", d, 32'(int'(sel) < nslots(d)), 32'd1);
        if (m_present[d]) begin
            for (int i = 0; i < nslots(d); i++) chk("array_do", d, 32'(arr[i]), 32'(m_words[d][i]));
        end
    endtask

    task automatic tick();
        model_edge(0, rst_a, valid_a, data_a, flush_a, fready_a);
        model_edge(1, rst_b, valid_b, data_b, flush_b, fready_b);
        @(posedge clk);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic push_a(logic [15:0] w);
        valid_a = 1'b1;
        data_a = w;
        tick();
        valid_a = 1'b0;
    endtask

    logic [15:0] t1 [4];
    logic [15:0] cnt_before;

    initial begin
        t1[0] = 16'h1111; t1[1] = 16'h2222; t1[2] = 16'h3333; t1[3] = 16'h4444;
        rst_a = 1; valid_a = 0; data_a = '0; flush_a = 0; fready_a = 0;
        rst_b = 1; valid_b = 0; data_b = '0; flush_b = 0; fready_b = 0;
        @(negedge clk);
        tick();
        tick();
        rst_a = 0; rst_b = 0;
        tick();

        // Stream one frame back-to-back with PE ready
        fready_a = 1;
        for (int i = 0; i < 4; i++) begin
            valid_a = 1; data_a = t1[i]; tick();
        end
        valid_a = 0;
        repeat (3) tick();

        // PE stalls: frame held, offered words ignored
        fready_a = 0;
        for (int i = 0; i < 4; i++) push_a(16'($urandom));
        tick();
        for (int i = 0; i < 10; i++) begin
            valid_a = 1; data_a = 16'($urandom); tick();
        end
        valid_a = 0; fready_a = 1;
        tick();
        fready_a = 0;
        tick();

        // Flush mid-frame beats a simultaneous word
        push_a(16'hA001);
        push_a(16'hA002);
        flush_a = 1; valid_a = 1; data_a = 16'hBEEF;
        tick();
        flush_a = 0; valid_a = 0;
        for (int i = 0; i < 4; i++) push_a(16'hC000 + 16'(i));
        tick();
        fready_a = 1; tick(); fready_a = 0;
        tick();

        // Flush and frame_ready together in FULL: no count
        for (int i = 0; i < 4; i++) push_a(16'($urandom));
        tick();
        tick();
        cnt_before = cnt_a;
        flush_a = 1; fready_a = 1;
        tick();
        flush_a = 0; fready_a = 0;
        chk("flush_no_count", 0, 32'(cnt_a), 32'(cnt_before));
        tick();

        // Reset while draining
        for (int i = 0; i < 4; i++) push_a(16'($urandom));
        rst_a = 1;
        tick();
        rst_a = 0;
        push_a(16'h5555);
        for (int i = 0; i < 3; i++) push_a(16'($urandom));
        tick();
        fready_a = 1; tick(); fready_a = 0;

        // Random traffic on the N=4 loader
        for (int i = 0; i < 300; i++) begin
            valid_a = 1'($urandom_range(0, 1));
            data_a = 16'($urandom);
            flush_a = ($urandom_range(0, 15) == 0);
            fready_a = 1'($urandom_range(0, 1));
            tick();
        end
        valid_a = 0; flush_a = 0; fready_a = 0;

        // N=3: three frames with random input gaps
        fready_b = 1;
        for (int i = 0; i < 200 && frames_done[1] < 3; i++) begin
            valid_b = 1'($urandom_range(0, 1));
            data_b = 16'($urandom);
            tick();
        end
        valid_b = 0; fready_b = 0;
        checks++;
        if (frames_done[1] < 3) begin
            errors++;
            $error("FAIL n3_frames_timeout observed=%0d expected=3", frames_done[1]);
        end
        chk("n3_frame_cnt", 1, 32'(cnt_b), CNT_EN ? 32'd3 : 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitlet_buffer_loader.md
Name: bitlet_buffer_loader

Overview:
Write-side sequencer for the Bitlet operand buffer array (N slots of W bits, one write port with write-enable and slot select). It accepts a stream of words over a valid/ready handshake and writes them into slots 0..N-1 in order. Once every slot is visible on the array outputs it presents the frame to the downstream PE and holds it until the PE acknowledges. It sits between the operand fetch stream and the buffer array, and is the only driver of the array's write port.

Parameters:
N, 4, number of buffer slots; legal range N >= 2.
W, 16, word width in bits.
SW, $clog2(N), slot-index width; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  reset, synchronous and active-high.
in_valid  input  1  an input word is offered.
in_data  input  W  input word.
in_ready  output  1  loader can accept a word this cycle.
flush  input  1  one-cycle pulse that abandons the current frame.
buf_enw  output  1  write enable to buffer array, registered, 1-cycle pulse.
buf_sel  output  SW  slot index to buffer array, registered.
buf_di  output  W  write data to buffer array, registered.
frame_valid  output  1  all N slots hold the current frame.
frame_ready  input  1  PE has consumed the frame.
fill_level  output  SW+1  number of words accepted in the current frame (0..N).
frame_cnt  output  16  number of completed frames; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clk edge): state=FILL, idx=0, fill_level=0, buf_enw=0, buf_sel=0, buf_di=0, frame_valid=0, frame_cnt=0. rst overrides every other input.
- A word is accepted on a cycle where in_valid && in_ready && !flush.
- FILL state: in_ready=1 and frame_valid=0.
  - On accept: the next cycle drives buf_enw=1, buf_sel=idx, buf_di=in_data. idx and fill_level each increment by 1.
  - When the accepted word is in slot N-1: go to DRAIN. idx wraps to 0 and fill_level becomes N.
  - With no accept: buf_enw=0 next cycle; buf_sel and buf_di hold their previous values.
- DRAIN state: lasts exactly one cycle. in_ready=0. The last write is on the array port during this cycle. Next state is FULL.
- FULL state: in_ready=0 and frame_valid=1.
  - Entering FULL: if the last word was accepted at edge t, frame_valid=1 from edge t+2, when the array outputs hold all N words.
  - On frame_valid && frame_ready: next state is FILL, fill_level=0, frame_valid=0 next cycle. in_ready becomes 1 in that same next cycle, so there are zero bubbles beyond the handshake.
- Back-to-back operation: the next frame's slot-0 write does not corrupt the consumed frame, because the PE samples DO in the handshake cycle.
- Throughput: one word per cycle in FILL. Frame period is N+2 cycles plus the PE wait.
- flush:
  - In FILL or DRAIN: next cycle idx=0, fill_level=0, state=FILL. Any in-flight buf_enw still completes; stale slot data is harmless because it is overwritten before the next frame_valid.
  - flush together with in_valid: flush wins and no word is accepted.
  - In FULL: frame_valid drops next cycle and state returns to FILL. frame_cnt does not increment, even if frame_ready is also high.
- buf_sel never exceeds N-1, including for non-power-of-2 N.

Optional Feature:
BITLET_LOADER_FRAME_CNT_EN
- Defined: frame_cnt increments by 1 on each frame_valid && frame_ready handshake that is not flushed. It wraps from 16'hFFFF to 0 and resets to 0.
- Undefined: the counter register is not built and frame_cnt is tied to 0. The port is always present.

Test Plan:
1. N=4, W=16, after reset: stream 0x1111, 0x2222, 0x3333, 0x4444 at one word per cycle, frame_ready=1 -> buf_enw pulses with buf_sel 0,1,2,3; frame_valid rises 2 cycles after the 4th accept; array DO = {4444,3333,2222,1111}; in_ready=1 the cycle after the handshake.
2. Fill 4 words with frame_ready=0 for 10 cycles -> frame_valid held at 1 and in_ready held at 0 for all 10 cycles; a raised in_valid is not accepted; DO unchanged.
3. Accept 2 words, then assert flush together with in_valid=1, data 0xBEEF -> 0xBEEF not accepted; fill_level=0; the next accepted word is written to slot 0.
4. In FULL, assert flush and frame_ready together -> frame_valid=0 next cycle, state FILL, frame_cnt unchanged (feature on).
5. Assert rst during DRAIN -> next cycle all outputs at reset values, in_ready=1, the next word goes to slot 0.
6. N=3, with the feature on, run 3 full frames with random in_valid gaps -> buf_sel sequence 0,1,2 repeating and never 3; frame_cnt=3.
